// File: rtl/fir_pkg.sv
// Shared constants, state encodings and payload types for the FIR coefficient controller.
package fir_pkg;

  localparam int unsigned NTAPS    = 16;
  localparam int unsigned CW       = 16;
  localparam int unsigned PIPE_LAT = 5;
  localparam int unsigned FILL_CYC = NTAPS + PIPE_LAT;
  localparam int unsigned WPW      = $clog2(NTAPS);
  localparam int unsigned FCW      = $clog2(FILL_CYC);
  localparam int unsigned TAPW     = NTAPS * CW;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_SWAP  = 3'd3;
  localparam logic [2:0] ST_FILL  = 3'd4;

  typedef logic [NTAPS-1:0][CW-1:0] tap_bank_t;

  typedef struct packed {
    logic          last;
    logic [CW-1:0] data;
  } cfg_beat_t;

  // Symmetric lowpass set, tap 0 in the least significant word.
  localparam tap_bank_t DEFAULT_TAPS = {
    16'h0000, 16'hFC9C, 16'h0000, 16'h05A5,
    16'h0000, 16'hF40C, 16'h0000, 16'h282D,
    16'h4000, 16'h282D, 16'h0000, 16'hF40C,
    16'h0000, 16'h05A5, 16'h0000, 16'hFC9C
  };

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Config-master <-> coefficient controller signal bundle.
interface fir_coef_ctrl_if;

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [fir_pkg::CW-1:0]    cfg_data;
  logic                      cfg_last;
  logic                      commit_req;
  logic                      commit_ack;
  logic                      fir_clear;
  logic [fir_pkg::TAPW-1:0]  taps;
  logic                      out_valid;
  logic                      busy;
  logic                      cfg_err;
  logic                      err_clr;

  modport master (
    output cfg_valid, cfg_data, cfg_last, commit_req, err_clr,
    input  cfg_ready, commit_ack, fir_clear, taps, out_valid, busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, commit_req, err_clr,
    output cfg_ready, commit_ack, fir_clear, taps, out_valid, busy, cfg_err
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair; shadow is written word by word, swap copies it to active.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_wr_en,
  input  logic [WPW-1:0] i_wr_addr,
  input  logic [CW-1:0]  i_wr_data,
  input  logic           i_swap,
  output tap_bank_t      o_active
);

  tap_bank_t r_shadow;
  tap_bank_t r_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= DEFAULT_TAPS;
      r_active <= DEFAULT_TAPS;
    end else begin
      if (i_wr_en) r_shadow[i_wr_addr] <= i_wr_data;
      if (i_swap)  r_active <= r_shadow;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load/commit sequencer for the FIR: shadow load, bank swap, pipeline clear and refill masking.
module fir_coef_ctrl
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fir_coef_ctrl_if.slave cfg_if
);

  logic [2:0]     r_state,       w_state_nx;
  logic [WPW-1:0] r_wr_ptr,      w_wr_ptr_nx;
  logic [FCW-1:0] r_fill_cnt,    w_fill_cnt_nx;
  logic           r_from_commit, w_from_commit_nx;
  logic           r_out_valid,   w_out_valid_nx;
  logic           r_commit_ack,  w_commit_ack_nx;
  logic           r_cfg_ready,   w_cfg_ready_nx;
  logic           r_fir_clear,   w_fir_clear_nx;
  logic           r_busy,        w_busy_nx;
  logic           r_cfg_err;
  logic           w_err_evt;
  logic           w_hs;
  logic           w_wr_en;
  logic [WPW-1:0] w_wr_addr;
  logic           w_swap;
  cfg_beat_t      w_beat;
  tap_bank_t      w_active;

  assign w_beat = '{last: cfg_if.cfg_last, data: cfg_if.cfg_data};
  assign w_hs   = cfg_if.cfg_valid & r_cfg_ready;

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nx       = r_state;
    w_wr_ptr_nx      = r_wr_ptr;
    w_fill_cnt_nx    = r_fill_cnt;
    w_from_commit_nx = r_from_commit;
    w_out_valid_nx   = r_out_valid;
    w_commit_ack_nx  = 1'b0;
    w_err_evt        = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_addr        = r_wr_ptr;
    w_swap           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_wr_addr = '0;
        if (w_hs) begin
          w_wr_en = 1'b1;
          if (w_beat.last) begin
            w_err_evt   = 1'b1;
            w_wr_ptr_nx = '0;
          end else begin
            w_wr_ptr_nx = WPW'(1);
            w_state_nx  = ST_LOAD;
          end
        end
        if (cfg_if.commit_req) w_err_evt = 1'b1;
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == WPW'(NTAPS - 1)) begin
            // A full set arms even without a last marker; the missing marker is flagged.
            w_wr_ptr_nx = '0;
            w_state_nx  = ST_ARMED;
            if (!w_beat.last) w_err_evt = 1'b1;
          end else if (w_beat.last) begin
            w_err_evt   = 1'b1;
            w_wr_ptr_nx = '0;
            w_state_nx  = ST_IDLE;
          end else begin
            w_wr_ptr_nx = r_wr_ptr + WPW'(1);
          end
        end
        if (cfg_if.commit_req) w_err_evt = 1'b1;
      end
      ST_ARMED: begin
        if (cfg_if.commit_req) w_state_nx = ST_SWAP;
      end
      ST_SWAP: begin
        w_swap           = 1'b1;
        w_out_valid_nx   = 1'b0;
        w_fill_cnt_nx    = '0;
        w_from_commit_nx = 1'b1;
        w_state_nx       = ST_FILL;
      end
      ST_FILL: begin
        if (r_fill_cnt == FCW'(FILL_CYC - 1)) begin
          w_out_valid_nx   = 1'b1;
          w_commit_ack_nx  = r_from_commit;
          w_from_commit_nx = 1'b0;
          w_state_nx       = ST_IDLE;
        end else begin
          w_fill_cnt_nx = r_fill_cnt + FCW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    w_cfg_ready_nx = (w_state_nx == ST_IDLE) || (w_state_nx == ST_LOAD);
    w_busy_nx      = !((w_state_nx == ST_IDLE) || (w_state_nx == ST_ARMED));
    w_fir_clear_nx = (w_state_nx == ST_SWAP);
  end

  // Reset lands in FILL so the FIR pipeline is masked until the default taps have propagated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_FILL;
      r_wr_ptr      <= '0;
      r_fill_cnt    <= '0;
      r_from_commit <= 1'b0;
      r_out_valid   <= 1'b0;
      r_commit_ack  <= 1'b0;
      r_cfg_ready   <= 1'b0;
      r_fir_clear   <= 1'b0;
      r_busy        <= 1'b1;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_wr_ptr      <= w_wr_ptr_nx;
      r_fill_cnt    <= w_fill_cnt_nx;
      r_from_commit <= w_from_commit_nx;
      r_out_valid   <= w_out_valid_nx;
      r_commit_ack  <= w_commit_ack_nx;
      r_cfg_ready   <= w_cfg_ready_nx;
      r_fir_clear   <= w_fir_clear_nx;
      r_busy        <= w_busy_nx;
      if (w_err_evt)           r_cfg_err <= 1'b1;
      else if (cfg_if.err_clr) r_cfg_err <= 1'b0;
    end
  end

  fir_coef_bank u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_beat.data),
    .i_swap    (w_swap),
    .o_active  (w_active)
  );

  assign cfg_if.taps       = w_active;
  assign cfg_if.cfg_ready  = r_cfg_ready;
  assign cfg_if.commit_ack = r_commit_ack;
  assign cfg_if.fir_clear  = r_fir_clear;
  assign cfg_if.out_valid  = r_out_valid;
  assign cfg_if.busy       = r_busy;
  assign cfg_if.cfg_err    = r_cfg_err;

endmodule
